// File: rtl/fpnew_norm_rs_gen_pkg.sv
// Shared types and helpers for the iterative normalizer / round-sticky generator.
package fpnew_norm_rs_gen_pkg;

    typedef enum logic [1:0] {
        NORM_IDLE,
        NORM_RUN,
        NORM_DONE
    } norm_state_e;

    // Width of the packed {exp field, mantissa field} result.
    function automatic int norm_abs_width(input int exp_width, input int man_width);
        return exp_width + man_width;
    endfunction

endpackage

// File: rtl/fpnew_norm_rs_gen_lzc.sv
// Leading-zero counter; an all-zero input reports the full width.
module fpnew_norm_rs_gen_lzc #(
    parameter int Width = 32,
    parameter int CntW  = $clog2(Width + 1)
) (
    input  logic [Width-1:0] in_i,
    output logic [CntW-1:0]  cnt_o
);

    // Scan upward so the highest set bit makes the last assignment.
    always_comb begin
        cnt_o = CntW'(Width);
        for (int i = 0; i < Width; i++) begin
            if (in_i[i]) cnt_o = CntW'(Width - 1 - i);
        end
    end

endmodule

// File: rtl/fpnew_rs_extract.sv
// Field and round/sticky extraction from the normalizer registers, with overflow saturation.
module fpnew_rs_extract
    import fpnew_norm_rs_gen_pkg::*;
#(
    parameter int ExpWidth = 8,
    parameter int ManWidth = 23,
    parameter int InWidth  = 32
) (
    input  logic [InWidth-1:0]                               mant_i,
    input  logic signed [ExpWidth+1:0]                       exp_i,
    input  logic                                             sticky_i,
    output logic [norm_abs_width(ExpWidth, ManWidth)-1:0]    abs_value_o,
    output logic [1:0]                                       rs_o,
    output logic                                             overflow_o
);

    localparam int EW2 = ExpWidth + 2;
    localparam logic signed [EW2-1:0] MaxExp = EW2'((1 << ExpWidth) - 1);

    logic [ExpWidth-1:0] exp_field;
    logic [ManWidth-1:0] man_field;
    logic                rnd;
    logic                stk;

    // Exponent 1 without the hidden bit is the subnormal encoding.
    assign exp_field  = (exp_i == EW2'(1) && !mant_i[InWidth-1]) ? '0 : exp_i[ExpWidth-1:0];
    assign man_field  = mant_i[InWidth-2 -: ManWidth];
    assign rnd        = mant_i[InWidth-2-ManWidth];
    assign stk        = (|mant_i[InWidth-3-ManWidth:0]) | sticky_i;
    assign overflow_o = (exp_i >= MaxExp);

    always_comb begin
        if (overflow_o) begin
            abs_value_o = {{ExpWidth{1'b1}}, {ManWidth{1'b0}}};
            rs_o        = 2'b00;
        end else begin
            abs_value_o = {exp_field, man_field};
            rs_o        = {rnd, stk};
        end
    end

endmodule

// File: rtl/fpnew_norm_rs_gen.sv
// Multi-cycle normalizer / denormalizer feeding the FPU rounder.
// Optional status_o port enabled by defining FPNEW_NORM_STATUS_EN.
module fpnew_norm_rs_gen
    import fpnew_norm_rs_gen_pkg::*;
#(
    parameter int ExpWidth  = 8,
    parameter int ManWidth  = 23,
    parameter int InWidth   = 32,
    parameter int ShiftStep = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    input  logic [InWidth-1:0]                            mant_i,
    input  logic signed [ExpWidth+1:0]                    exp_i,
    input  logic                                          sign_i,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [norm_abs_width(ExpWidth, ManWidth)-1:0] abs_value_o,
    output logic [1:0]                                    round_sticky_bits_o,
    output logic                                          sign_o,
    output logic                                          overflow_o
`ifdef FPNEW_NORM_STATUS_EN
    ,
    output logic [2:0]                                    status_o
`endif
);

    localparam int EW2 = ExpWidth + 2;
    localparam int DW  = ExpWidth + 4;   // headroom so 1-exp never wraps
    localparam int CW  = $clog2(InWidth + 1);

    norm_state_e             state_q, state_d;
    logic [InWidth-1:0]      mant_q, mant_d;
    logic signed [EW2-1:0]   exp_q, exp_d;
    logic                    sticky_q, sticky_d;
    logic                    sign_q, sign_d;

    logic [CW-1:0]           lz_cnt;
    logic signed [DW-1:0]    exp_w, rdist, em1;
    logic [DW-1:0]           sh;
    logic [InWidth-1:0]      lost;

    fpnew_norm_rs_gen_lzc #(.Width(InWidth), .CntW(CW)) i_lzc (
        .in_i  (mant_q),
        .cnt_o (lz_cnt)
    );

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sticky_d = sticky_q;
        sign_d   = sign_q;
        exp_w    = DW'(exp_q);
        rdist    = DW'(1) - exp_w;
        em1      = exp_w - DW'(1);
        sh       = '0;
        lost     = '0;
        case (state_q)
            NORM_IDLE: begin
                if (in_valid_i) begin
                    mant_d   = mant_i;
                    exp_d    = exp_i;
                    sign_d   = sign_i;
                    sticky_d = 1'b0;
                    state_d  = NORM_RUN;
                end
            end
            NORM_RUN: begin
                if (mant_q == '0) begin
                    exp_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = NORM_DONE;
                end else if (exp_w < DW'(1)) begin
                    // Too far below range: everything lands in sticky at once.
                    if (rdist >= DW'(InWidth)) begin
                        sticky_d = 1'b1;
                        mant_d   = '0;
                        exp_d    = EW2'(1);
                        state_d  = NORM_DONE;
                    end else begin
                        sh       = (rdist > DW'(ShiftStep)) ? DW'(ShiftStep) : rdist;
                        lost     = mant_q & ~({InWidth{1'b1}} << sh);
                        sticky_d = sticky_q | (|lost);
                        mant_d   = mant_q >> sh;
                        exp_d    = exp_q + EW2'(sh);
                    end
                end else if (!mant_q[InWidth-1] && exp_w > DW'(1)) begin
                    sh = DW'(lz_cnt);
                    if (sh > DW'(ShiftStep)) sh = DW'(ShiftStep);
                    if (sh > $unsigned(em1)) sh = $unsigned(em1);
                    mant_d = mant_q << sh;
                    exp_d  = exp_q - EW2'(sh);
                end else begin
                    state_d = NORM_DONE;
                end
            end
            NORM_DONE: begin
                if (out_ready_i) state_d = NORM_IDLE;
            end
            default: state_d = NORM_IDLE;
        endcase
        if (flush_i) state_d = NORM_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= NORM_IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
        end
    end

    fpnew_rs_extract #(
        .ExpWidth (ExpWidth),
        .ManWidth (ManWidth),
        .InWidth  (InWidth)
    ) i_extract (
        .mant_i      (mant_q),
        .exp_i       (exp_q),
        .sticky_i    (sticky_q),
        .abs_value_o (abs_value_o),
        .rs_o        (round_sticky_bits_o),
        .overflow_o  (overflow_o)
    );

    assign in_ready_o  = (state_q == NORM_IDLE);
    assign out_valid_o = (state_q == NORM_DONE);
    assign sign_o      = sign_q;

`ifdef FPNEW_NORM_STATUS_EN
    assign status_o = {overflow_o,
                       (abs_value_o[ExpWidth+ManWidth-1 -: ExpWidth] == '0) && (mant_q != '0),
                       |round_sticky_bits_o};
`endif

endmodule

// File: tb/tb_fpnew_norm_rs_gen.sv
// Directed scoreboard bench for fpnew_norm_rs_gen at 8/23/32/8.
module tb_fpnew_norm_rs_gen;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        mant = '0;
    logic signed [9:0]  expn = '0;
    logic               sgn = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [30:0]        abs_v;
    logic [1:0]         rs;
    logic               sign_out;
    logic               ovf;
`ifdef FPNEW_NORM_STATUS_EN
    logic [2:0]         status;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [30:0] abs_v;
        logic [1:0]  rs;
        logic        ovf;
        logic        sgn;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fpnew_norm_rs_gen #(
        .ExpWidth(8), .ManWidth(23), .InWidth(32), .ShiftStep(8)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (flush),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .mant_i              (mant),
        .exp_i               (expn),
        .sign_i              (sgn),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .abs_value_o         (abs_v),
        .round_sticky_bits_o (rs),
        .sign_o              (sign_out),
        .overflow_o          (ovf)
`ifdef FPNEW_NORM_STATUS_EN
        ,
        .status_o            (status)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction, hold backpressure for `hold` cycles, then drain and score it.
    task automatic xact(input string tag, input logic [31:0] m, input logic signed [9:0] e,
                        input logic s, input logic [30:0] eabs, input logic [1:0] ers,
                        input logic eovf, input int ncyc, input int hold);
        exp_t ex;
        exp_t got;
        int   cnt;
        ex.abs_v = eabs; ex.rs = ers; ex.ovf = eovf; ex.sgn = s;
        sb.push_back(ex);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; mant = m; expn = e; sgn = s;
        step();
        in_valid = 1'b0; mant = '0; expn = '0; sgn = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            step();
            cnt++;
        end
        chk({tag, "_done"}, out_valid, 1);
        if (ncyc > 0) chk({tag, "_norm_cycles"}, cnt, ncyc);
        got = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_abs"}, abs_v, got.abs_v);
            chk({tag, "_hold_rdy"}, {in_ready, out_valid}, 2'b01);
            step();
        end
        chk({tag, "_abs"}, abs_v, got.abs_v);
        chk({tag, "_rs"}, rs, got.rs);
        chk({tag, "_ovf"}, ovf, got.ovf);
        chk({tag, "_sign"}, sign_out, got.sgn);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #2;
        chk("rst_state", {in_ready, out_valid, abs_v, rs, sign_out, ovf}, {2'b10, 31'h0, 2'b00, 1'b0, 1'b0});
        step();
        rst_n = 1'b1;
        step();

        xact("one",       32'h8000_0000, 10'sd127, 1'b0, 31'h3F80_0000, 2'b00, 1'b0, 1, 0);
        xact("lsb",       32'h0000_0001, 10'sd127, 1'b1, 31'h3000_0000, 2'b00, 1'b0, 5, 0);
        xact("round",     32'h8000_0180, 10'sd127, 1'b0, 31'h3F80_0001, 2'b10, 1'b0, 0, 0);
        xact("rnd_stk",   32'h8000_01C0, 10'sd127, 1'b1, 31'h3F80_0001, 2'b11, 1'b0, 0, 0);
        xact("denorm2",   32'h8000_0000, -10'sd2,  1'b0, 31'h0010_0000, 2'b00, 1'b0, 0, 0);
        xact("collapse",  32'h8000_0000, -10'sd40, 1'b1, 31'h0000_0000, 2'b01, 1'b0, 0, 0);
        xact("overflow",  32'h8000_0000, 10'sd255, 1'b1, 31'h7F80_0000, 2'b00, 1'b1, 0, 0);
        xact("zero",      32'h0000_0000, 10'sd255, 1'b0, 31'h0000_0000, 2'b00, 1'b0, 0, 0);
        xact("lsh_clamp", 32'h0001_0000, 10'sd5,   1'b0, 31'h0000_1000, 2'b00, 1'b0, 0, 0);
        xact("rsh_stk",   32'h8000_00FF, -10'sd7,  1'b0, 31'h0000_8000, 2'b01, 1'b0, 0, 0);
        xact("rsh_multi", 32'h8000_0000, -10'sd9,  1'b1, 31'h0000_2000, 2'b00, 1'b0, 0, 0);
        xact("backpress", 32'h8000_0180, 10'sd127, 1'b0, 31'h3F80_0001, 2'b10, 1'b0, 0, 5);

        // Flush while shifting: nothing comes out and the block is idle again.
        in_valid = 1'b1; mant = 32'h0000_0001; expn = 10'sd127;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle", {in_ready, out_valid}, 2'b10);
        for (int i = 0; i < 6; i++) step();
        chk("flush_no_out", out_valid, 0);
        xact("after_flush", 32'h8000_0000, 10'sd127, 1'b0, 31'h3F80_0000, 2'b00, 1'b0, 1, 0);

        // Asynchronous reset in the middle of a shift sequence.
        in_valid = 1'b1; mant = 32'h0000_0001; expn = 10'sd127; sgn = 1'b1;
        step();
        in_valid = 1'b0; sgn = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {in_ready, out_valid, abs_v, rs, sign_out, ovf}, {2'b10, 31'h0, 2'b00, 1'b0, 1'b0});
        step();
        rst_n = 1'b1;
        step();
        xact("after_rst", 32'h8000_0180, 10'sd127, 1'b1, 31'h3F80_0001, 2'b10, 1'b0, 0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
